// File: rtl/matriz_resultado_serializador_pkg.sv
// ============================================================================
// Module  : matriz_resultado_serializador_pkg
// Brief   : Shared element width and serializer state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package matriz_resultado_serializador_pkg;

  localparam int ELEM_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/matriz_resultado_serializador_if.sv
// ============================================================================
// Module  : matriz_resultado_serializador_if
// Brief   : Valid/ready element stream from the serializer to the memory writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface matriz_resultado_serializador_if
  import matriz_resultado_serializador_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N*N)
) ();

  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/matriz_resultado_serializador.sv
// ============================================================================
// Module  : matriz_resultado_serializador
// Brief   : Captures an N*N x 9-bit result vector and streams it element by element.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matriz_resultado_serializador
  import matriz_resultado_serializador_pkg::*;
#(
  parameter int N = 3
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    start,
  input  wire logic [N*N*ELEM_W-1:0]   matriz_resultado,
  output logic                         busy,
  output logic                         done,
  matriz_resultado_serializador_if.master out_if
);

  localparam int                NUM_ELEM = N*N;
  localparam int                IDX_W    = $clog2(NUM_ELEM);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ELEM - 1);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_ELEM*ELEM_W-1:0]  cap_q, cap_d;

  logic send_active;
  logic beat_accepted;

  assign send_active   = (state_q == ST_SEND);
  assign beat_accepted = send_active && out_if.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
    end
  end

  // The capture register is only written from IDLE, so start during a stream is ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cap_d   = matriz_resultado;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_accepted) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_if.out_valid = send_active;
  assign out_if.out_data  = cap_q[int'(idx_q)*ELEM_W +: ELEM_W];
  assign out_if.out_index = idx_q;
  assign out_if.out_last  = send_active && (idx_q == LAST_IDX);
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_matriz_resultado_serializador.sv
// ============================================================================
// Module  : tb_matriz_resultado_serializador
// Brief   : Directed table-driven and sequence checks of the result serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matriz_resultado_serializador;
  import matriz_resultado_serializador_pkg::*;

  localparam int N  = 3;
  localparam int NE = N*N;

  typedef struct {
    logic       st;
    logic       rdy;
    logic       v;
    logic [8:0] d;
    logic [3:0] ix;
    logic       l;
    logic       b;
    logic       dn;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NE*9-1:0] mat;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  matriz_resultado_serializador_if #(.N(N)) bus ();

  matriz_resultado_serializador #(.N(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .matriz_resultado (mat),
    .busy             (busy),
    .done             (done),
    .out_if           (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data and index are only meaningful while out_valid is high.
  task automatic outs(input string tag, input logic v, input logic [8:0] d,
                      input logic [3:0] ix, input logic l, input logic b, input logic dn);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      chk({tag, ".data"},  32'(bus.out_data),  32'(d));
      chk({tag, ".index"}, 32'(bus.out_index), 32'(ix));
    end
    chk({tag, ".last"}, 32'(bus.out_last), 32'(l));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  // Entered on the first SEND cycle; ends after checking the IDLE cycle after DONE.
  task automatic run_stream(input string tag, input logic [NE*9-1:0] v,
                            input int inject_at, input logic [NE*9-1:0] inj);
    bus.out_ready = 1'b1;
    for (int i = 0; i < NE; i++) begin
      if (i == inject_at) begin
        start = 1'b1;
        mat   = inj;
      end else begin
        start = 1'b0;
      end
      outs($sformatf("%s.beat%0d", tag, i), 1'b1, v[i*9 +: 9], 4'(i), (i == NE-1), 1'b1, 1'b0);
      step();
    end
    start = 1'b0;
    outs({tag, ".done"}, 1'b0, 9'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    outs({tag, ".idle"}, 1'b0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t            tbl [12];
    logic [NE*9-1:0] va, vb, vc, vj;
    logic [8:0]      bp [NE];
    logic [8:0]      bp_vals [3];
    int              exp_ix;
    int              cyc;
    bit              fin;

    // Full stream of 0x001..0x009 with out_ready held high.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 9'h001, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 9'h002, 4'd1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 9'h003, 4'd2, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 9'h004, 4'd3, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 9'h005, 4'd4, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 9'h006, 4'd5, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 9'h007, 4'd6, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 9'h008, 4'd7, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 9'h009, 4'd8, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 9'h000, 4'd0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 1'b0};

    bp_vals[0] = 9'h1FF;
    bp_vals[1] = 9'h100;
    bp_vals[2] = 9'h0FF;

    // Reset asserted before the first edge must clear outputs asynchronously.
    reset         = 1'b1;
    start         = 1'b0;
    bus.out_ready = 1'b0;
    mat           = '0;
    #2;
    outs("reset_async", 1'b0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_async.data",  32'(bus.out_data),  32'd0);
    chk("reset_async.index", 32'(bus.out_index), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    outs("reset_release", 1'b0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NE; i++) mat[i*9 +: 9] = 9'(i + 1);
    for (int r = 0; r < 12; r++) begin
      start         = tbl[r].st;
      bus.out_ready = tbl[r].rdy;
      outs($sformatf("full.row%0d", r), tbl[r].v, tbl[r].d, tbl[r].ix, tbl[r].l, tbl[r].b, tbl[r].dn);
      step();
    end
    start = 1'b0;

    // Backpressure: ready pattern 1,0,0 repeating; each element must appear once, in order.
    for (int i = 0; i < NE; i++) begin
      bp[i] = bp_vals[i % 3];
      mat[i*9 +: 9] = bp[i];
    end
    start         = 1'b1;
    bus.out_ready = 1'b0;
    step();
    start  = 1'b0;
    exp_ix = 0;
    cyc    = 0;
    fin    = 1'b0;
    while (!fin && cyc < 60) begin
      bus.out_ready = ((cyc % 3) == 0);
      outs($sformatf("bp.cyc%0d", cyc), 1'b1, bp[exp_ix], 4'(exp_ix), (exp_ix == NE-1), 1'b1, 1'b0);
      if (bus.out_ready) begin
        if (exp_ix == NE-1) fin = 1'b1;
        else exp_ix++;
      end
      step();
      cyc++;
    end
    chk("bp.completed_in_budget", 32'(fin), 32'd1);
    bus.out_ready = 1'b0;
    outs("bp.done", 1'b0, 9'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    outs("bp.idle", 1'b0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // start with a new vector at beat 4 is ignored and never queued.
    for (int i = 0; i < NE; i++) begin
      va[i*9 +: 9] = 9'(9'h020 + 9'(i * 17));
      vb[i*9 +: 9] = 9'(9'h1C0 - 9'(i * 5));
    end
    mat   = va;
    start = 1'b1;
    step();
    run_stream("ignore", va, 4, vb);
    for (int i = 0; i < 3; i++) begin
      step();
      outs($sformatf("ignore.quiet%0d", i), 1'b0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end

    // Reset while index 5 is on the bus abandons the stream without a done pulse.
    mat   = va;
    start = 1'b1;
    step();
    start         = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    outs("midrst.pre", 1'b1, va[5*9 +: 9], 4'd5, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    outs("midrst.async", 1'b0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("midrst.data",  32'(bus.out_data),  32'd0);
    chk("midrst.index", 32'(bus.out_index), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      outs($sformatf("midrst.idle%0d", i), 1'b0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < NE; i++) vc[i*9 +: 9] = 9'(9'h1F0 + 9'(i));
    mat   = vc;
    start = 1'b1;
    step();
    run_stream("restart", vc, -1, '0);

    // Back-to-back: start in the IDLE cycle right after DONE, input scrambled after capture.
    for (int i = 0; i < NE; i++) vj[i*9 +: 9] = 9'(9'h0A0 + 9'(i * 3));
    mat   = vj;
    start = 1'b1;
    step();
    mat = ~vj;
    run_stream("b2b_first", vj, -1, '0);
    mat   = vc;
    start = 1'b1;
    step();
    mat = '1;
    run_stream("b2b_second", vc, -1, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
